// File: rtl/ws2812_tx_sequencer.sv
// rtl/ws2812_tx_sequencer.sv - WS2812 frame sequencer: pixel RAM walk, bit-cell serialiser, latch period
`timescale 1ns/1ps
module ws2812_tx_sequencer #(
  parameter int MAX_PIXELS   = 4,
  parameter int BIT_CYCLES   = 34,
  parameter int T0H_CYCLES   = 11,
  parameter int T1H_CYCLES   = 22,
  parameter int RESET_CYCLES = 2160
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] number_of_pixels,
  input  logic       refresh,
  output logic [9:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       ws2812_dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CELL  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [9:0]    rd_addr_q, rd_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dout_q, dout_d;
  logic          pend_q, pend_d;
  logic [7:0]    n_q, n_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    next_q, next_d;
  logic [9:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]    n_req;
  logic [9:0]    total_bytes;
  logic          more_bytes;
  logic [CW-1:0] high_len;

  always_comb begin
    n_req       = (number_of_pixels > 8'(MAX_PIXELS)) ? 8'(MAX_PIXELS) : number_of_pixels;
    total_bytes = {2'b00, n_q} * 10'd3;
    more_bytes  = (byte_q + 10'd1) < total_bytes;
    high_len    = shift_q[bit_q] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    n_d       = n_q;
    shift_d   = shift_q;
    next_d    = next_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    // Output lags the state by one register stage, so it is computed from the current cell.
    dout_d    = (state_q == S_CELL) && (cnt_q < high_len);

    if (busy_q && refresh) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (refresh) begin
          if (n_req != 8'd0) begin
            n_d       = n_req;
            rd_addr_d = 10'd0;
            busy_d    = 1'b1;
            state_d   = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = rd_data;
        byte_d  = 10'd0;
        bit_d   = 3'd7;
        cnt_d   = '0;
        state_d = S_CELL;
      end
      S_CELL: begin
        // Prefetch during the last bit: address at cycle 0, RAM data valid at cycle 2.
        if (bit_q == 3'd0 && more_bytes) begin
          if (cnt_q == '0) rd_addr_d = byte_q + 10'd1;
          if (cnt_q == CW'(2)) next_d = rd_data;
        end
        if (cnt_q == CW'(BIT_CYCLES - 1)) begin
          cnt_d = '0;
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
          end else if (more_bytes) begin
            shift_d = next_q;
            byte_d  = byte_q + 10'd1;
            bit_d   = 3'd7;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        // One extra count covers the output register delay so the line is low RESET_CYCLES.
        if (cnt_q == CW'(RESET_CYCLES)) begin
          done_d = 1'b1;
          cnt_d  = '0;
          pend_d = 1'b0;
          if ((pend_q || refresh) && n_req != 8'd0) begin
            n_d       = n_req;
            rd_addr_d = 10'd0;
            state_d   = S_FETCH;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= 1'b0;
      pend_q    <= 1'b0;
      n_q       <= '0;
      shift_q   <= '0;
      next_q    <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      pend_q    <= pend_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      next_q    <= next_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign ws2812_dout = dout_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: doc/ws2812_tx_sequencer.md
Name: ws2812_tx_sequencer

Overview:
- Transmit controller for the WS2812 LED strip.
- On a refresh request it walks the pixel RAM from byte 0 to number_of_pixels*3-1 through the RAM's second (read-only) port.
- It serialises each byte MSB-first onto the single-wire WS2812 line with programmable bit-cell timing, then holds the line low for the latch/reset period.
- Sits between the pixel RAM (written by the CPU register block) and the strip output pin.

Parameters:
- MAX_PIXELS, 4: upper clamp on number_of_pixels.
- BIT_CYCLES, 34: clk cycles per bit cell (1.25 us at 27 MHz).
- T0H_CYCLES, 11: high time for a 0 bit; must be less than T1H_CYCLES.
- T1H_CYCLES, 22: high time for a 1 bit; must be less than BIT_CYCLES.
- RESET_CYCLES, 2160: low time after the last bit (80 us at 27 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- number_of_pixels  in  8  LEDs on strip; sampled at start of each frame
- refresh  in  1  single-cycle request to send one frame
- rd_addr  out  10  pixel RAM read address
- rd_data  in  8  pixel RAM read data, valid 1 cycle after rd_addr (synchronous RAM)
- ws2812_dout  out  1  serial line to strip
- busy  out  1  high from frame accept until end of reset period
- frame_done  out  1  one-cycle pulse when the reset period completes

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values:
  - state IDLE
  - rd_addr=0, ws2812_dout=0, busy=0, frame_done=0
  - pending=0, all counters 0
- Frame length:
  - n = min(number_of_pixels, MAX_PIXELS), latched on frame accept.
  - total_bytes = n*3, computed 10 bits wide (max 765, no overflow).
- State IDLE:
  - On refresh=1 with n>0: rd_addr<=0, busy<=1, go to FETCH.
  - On refresh=1 with n=0: no line activity; frame_done pulses the next cycle, busy stays 0.
- State FETCH (1 cycle): waits for RAM latency, then goes to LOAD.
- State LOAD (1 cycle):
  - shift_reg<=rd_data, byte_idx<=0, bit_idx<=7, cell counter<=0.
  - Go to CELL. The first rising edge of ws2812_dout occurs 3 cycles after refresh.
- State CELL, per bit:
  - ws2812_dout=1 while cell counter < (bit ? T1H_CYCLES : T0H_CYCLES), else 0.
  - Counter runs 0..BIT_CYCLES-1; each bit lasts exactly BIT_CYCLES cycles.
- Prefetch: on cycle 0 of bit_idx=0 of byte k, with k+1 < total_bytes:
  - rd_addr<=k+1, and rd_data is captured into next_byte on the following cycle.
  - At the end of bit 0, shift_reg<=next_byte and byte_idx increments.
  - The stream is contiguous; no gap between bytes or pixels.
- After bit 0 of the byte at total_bytes-1: go to LATCH with ws2812_dout=0.
- State LATCH:
  - Counts RESET_CYCLES with the line low.
  - On completion: frame_done=1 for 1 cycle.
  - If pending=1: clear pending and start a new frame (re-latch n, go to FETCH); busy stays 1.
  - Otherwise: busy<=0 and go to IDLE.
- refresh while busy: sets pending. Multiple requests collapse into one further frame. The current frame is never truncated or restarted.
- Changes to number_of_pixels mid-frame have no effect until the next frame accept.
- rd_addr holds its last value when not fetching. RAM contents written by the CPU mid-frame are sent if their byte has not yet been fetched.
- Asserting reset mid-frame: ws2812_dout drops to 0 immediately and all state returns to reset values. The strip sees a truncated frame followed by an idle low line, which it treats as a reset.
- Bit order on the wire: RAM byte order 0,1,2,... with each byte MSB first. The colour order (GRB) is the software's responsibility.

Test Plan (BIT_CYCLES=10, T0H=3, T1H=7, RESET_CYCLES=20, MAX_PIXELS=4):
- Single pixel:
  - Stimulus: number_of_pixels=1, RAM[0..2]=A5,00,FF, pulse refresh.
  - Required: 24 cells of 10 cycles each, pattern 1,0,1,0,0,1,0,1 then eight 0s then eight 1s.
  - Required: high times 7/3 accordingly; line then low for 20 cycles; frame_done exactly 260 cycles after the first rising edge; busy falls with it.
- Contiguity:
  - Stimulus: number_of_pixels=2, all bytes 80.
  - Required: rising edges spaced exactly 10 cycles apart across all 48 bits, including the boundaries between byte 2 and byte 3.
  - Required: rd_addr sequence 0..5.
- Clamp and zero:
  - Stimulus: number_of_pixels=9.
  - Required: exactly 96 bit cells sent (4 pixels), last rd_addr=11.
  - Stimulus: number_of_pixels=0 with refresh.
  - Required: no edge on ws2812_dout; frame_done pulses 1 cycle later.
- Pending:
  - Stimulus: pulse refresh 3 times during a frame.
  - Required: exactly one further frame starts after the first frame's frame_done; busy stays high throughout; 2 frame_done pulses in total.
- Mid-frame change:
  - Stimulus: change number_of_pixels from 2 to 1 during bit 5.
  - Required: the current frame still sends 48 bits; the next frame sends 24 bits.
- Reset:
  - Stimulus: assert reset_n=0 during the high phase of a cell.
  - Required: ws2812_dout=0 in the same cycle without waiting for a clock edge; busy=0; rd_addr=0; after release the block is in IDLE and accepts a new refresh.
